// File: rtl/wb_reg_timeout.sv
// wb_reg_timeout: registered Wishbone classic slice with a per-transfer
// watchdog and automatic retry.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   m_* (inputs)             master request: adr/dat/we/sel/stb/cyc
//   m_dat_o, m_ack_o,
//   m_err_o, m_rty_o         registered response to master, one-cycle pulse
//   s_* (outputs)            registered request to slave
//   s_dat_i, s_ack_i,
//   s_err_i, s_rty_i         slave response
//   timeout_o                one-cycle pulse when the watchdog ends a transfer
//   retry_o                  one-cycle pulse on each automatic reissue
//
// Handshake: a request is accepted in IDLE when m_cyc_i && m_stb_i. The slave
// sees s_cyc_o/s_stb_o held until it returns exactly one of ack/err/rty (the
// first one seen wins, ack > err > rty). The master sees one response pulse,
// one cycle after the slave response, and must keep m_cyc_i high until then;
// dropping m_cyc_i abandons the transfer without a response.
module wb_reg_timeout #(
  parameter int DATA_WIDTH   = 32,
  parameter int ADDR_WIDTH   = 32,
  parameter int SELECT_WIDTH = DATA_WIDTH / 8,
  parameter int TIMEOUT      = 1024,
  parameter int RETRY_LIMIT  = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [ADDR_WIDTH-1:0]   m_adr_i,
  input  logic [DATA_WIDTH-1:0]   m_dat_i,
  output logic [DATA_WIDTH-1:0]   m_dat_o,
  input  logic                    m_we_i,
  input  logic [SELECT_WIDTH-1:0] m_sel_i,
  input  logic                    m_stb_i,
  output logic                    m_ack_o,
  output logic                    m_err_o,
  output logic                    m_rty_o,
  input  logic                    m_cyc_i,
  output logic [ADDR_WIDTH-1:0]   s_adr_o,
  input  logic [DATA_WIDTH-1:0]   s_dat_i,
  output logic [DATA_WIDTH-1:0]   s_dat_o,
  output logic                    s_we_o,
  output logic [SELECT_WIDTH-1:0] s_sel_o,
  output logic                    s_stb_o,
  input  logic                    s_ack_i,
  input  logic                    s_err_i,
  input  logic                    s_rty_i,
  output logic                    s_cyc_o,
  output logic                    timeout_o,
  output logic                    retry_o
);

  // Zero-valued parameters would give zero-width counters; keep at least 1 bit.
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RW = (RETRY_LIMIT > 0) ? $clog2(RETRY_LIMIT + 1) : 1;
  localparam logic [TW-1:0] TIMER_LOAD = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [RW-1:0] RETRY_MAX  = RW'(RETRY_LIMIT);

  typedef enum logic [1:0] {IDLE, ISSUE, BACKOFF, RESP} state_t;

  state_t                  state_q, state_d;
  logic [TW-1:0]           timer_q, timer_d;
  logic [RW-1:0]           retry_cnt_q, retry_cnt_d;
  logic [ADDR_WIDTH-1:0]   s_adr_q, s_adr_d;
  logic [DATA_WIDTH-1:0]   s_dat_q, s_dat_d;
  logic                    s_we_q, s_we_d;
  logic [SELECT_WIDTH-1:0] s_sel_q, s_sel_d;
  logic                    s_cyc_q, s_cyc_d;
  logic                    s_stb_q, s_stb_d;
  logic [DATA_WIDTH-1:0]   m_dat_q, m_dat_d;
  logic                    m_ack_q, m_ack_d;
  logic                    m_err_q, m_err_d;
  logic                    m_rty_q, m_rty_d;
  logic                    timeout_q, timeout_d;
  logic                    retry_q, retry_d;

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    retry_cnt_d = retry_cnt_q;
    s_adr_d     = s_adr_q;
    s_dat_d     = s_dat_q;
    s_we_d      = s_we_q;
    s_sel_d     = s_sel_q;
    s_cyc_d     = s_cyc_q;
    s_stb_d     = s_stb_q;
    m_dat_d     = m_dat_q;
    // Response and event outputs are pulses: low unless set below.
    m_ack_d     = 1'b0;
    m_err_d     = 1'b0;
    m_rty_d     = 1'b0;
    timeout_d   = 1'b0;
    retry_d     = 1'b0;

    case (state_q)
      IDLE: begin
        if (m_cyc_i && m_stb_i) begin
          s_adr_d     = m_adr_i;
          s_dat_d     = m_dat_i;
          s_we_d      = m_we_i;
          s_sel_d     = m_sel_i;
          s_cyc_d     = 1'b1;
          s_stb_d     = 1'b1;
          timer_d     = TIMER_LOAD;
          retry_cnt_d = '0;
          state_d     = ISSUE;
        end
      end

      ISSUE: begin
        // Master abort outranks anything the slave says this cycle.
        if (!m_cyc_i) begin
          s_cyc_d = 1'b0;
          s_stb_d = 1'b0;
          state_d = IDLE;
        end else if (s_ack_i) begin
          s_cyc_d = 1'b0;
          s_stb_d = 1'b0;
          m_dat_d = s_dat_i;
          m_ack_d = 1'b1;
          state_d = RESP;
        end else if (s_err_i) begin
          s_cyc_d = 1'b0;
          s_stb_d = 1'b0;
          m_err_d = 1'b1;
          state_d = RESP;
        end else if (s_rty_i) begin
          s_cyc_d = 1'b0;
          s_stb_d = 1'b0;
          if (retry_cnt_q < RETRY_MAX) begin
            retry_cnt_d = retry_cnt_q + RW'(1);
            retry_d     = 1'b1;
            state_d     = BACKOFF;
          end else begin
            m_rty_d = 1'b1;
            state_d = RESP;
          end
        end else if (TIMEOUT != 0) begin
          if (timer_q == '0) begin
            s_cyc_d   = 1'b0;
            s_stb_d   = 1'b0;
            m_err_d   = 1'b1;
            timeout_d = 1'b1;
            state_d   = RESP;
          end else begin
            timer_d = timer_q - TW'(1);
          end
        end
      end

      BACKOFF: begin
        // One idle bus cycle, then reissue the captured request.
        if (!m_cyc_i) begin
          state_d = IDLE;
        end else begin
          s_cyc_d = 1'b1;
          s_stb_d = 1'b1;
          timer_d = TIMER_LOAD;
          state_d = ISSUE;
        end
      end

      RESP: begin
        // The master still holds stb this cycle; it is the finished request.
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      retry_cnt_q <= '0;
      s_adr_q     <= '0;
      s_dat_q     <= '0;
      s_we_q      <= 1'b0;
      s_sel_q     <= '0;
      s_cyc_q     <= 1'b0;
      s_stb_q     <= 1'b0;
      m_dat_q     <= '0;
      m_ack_q     <= 1'b0;
      m_err_q     <= 1'b0;
      m_rty_q     <= 1'b0;
      timeout_q   <= 1'b0;
      retry_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      retry_cnt_q <= retry_cnt_d;
      s_adr_q     <= s_adr_d;
      s_dat_q     <= s_dat_d;
      s_we_q      <= s_we_d;
      s_sel_q     <= s_sel_d;
      s_cyc_q     <= s_cyc_d;
      s_stb_q     <= s_stb_d;
      m_dat_q     <= m_dat_d;
      m_ack_q     <= m_ack_d;
      m_err_q     <= m_err_d;
      m_rty_q     <= m_rty_d;
      timeout_q   <= timeout_d;
      retry_q     <= retry_d;
    end
  end

  assign s_adr_o   = s_adr_q;
  assign s_dat_o   = s_dat_q;
  assign s_we_o    = s_we_q;
  assign s_sel_o   = s_sel_q;
  assign s_cyc_o   = s_cyc_q;
  assign s_stb_o   = s_stb_q;
  assign m_dat_o   = m_dat_q;
  assign m_ack_o   = m_ack_q;
  assign m_err_o   = m_err_q;
  assign m_rty_o   = m_rty_q;
  assign timeout_o = timeout_q;
  assign retry_o   = retry_q;

endmodule

// File: tb/tb_wb_reg_timeout.sv
// Bench for wb_reg_timeout. dut runs TIMEOUT=8, RETRY_LIMIT=2; dut_z runs
// TIMEOUT=0, RETRY_LIMIT=0 on the same master/slave inputs. Master responses
// are predicted into exp_q as {code, data} (code 1=ack 2=err 3=rty) when a
// request is driven and popped when the DUT answers.
module tb_wb_reg_timeout;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] m_adr_i = '0, m_dat_i = '0, s_dat_i = '0;
  logic        m_we_i = 1'b0, m_stb_i = 1'b0, m_cyc_i = 1'b0;
  logic [3:0]  m_sel_i = '0;
  logic        s_ack_i = 1'b0, s_err_i = 1'b0, s_rty_i = 1'b0;

  logic [31:0] m_dat_o, s_adr_o, s_dat_o;
  logic        m_ack_o, m_err_o, m_rty_o, s_we_o, s_stb_o, s_cyc_o, timeout_o, retry_o;
  logic [3:0]  s_sel_o;
  logic [31:0] z_m_dat_o, z_s_adr_o, z_s_dat_o;
  logic        z_m_ack_o, z_m_err_o, z_m_rty_o, z_s_we_o, z_s_stb_o, z_s_cyc_o, z_timeout_o, z_retry_o;
  logic [3:0]  z_s_sel_o;

  logic [33:0] exp_q[$];
  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  wb_reg_timeout #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT(8), .RETRY_LIMIT(2)) dut (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(m_dat_o), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_stb_i(m_stb_i), .m_ack_o(m_ack_o), .m_err_o(m_err_o), .m_rty_o(m_rty_o), .m_cyc_i(m_cyc_i),
    .s_adr_o(s_adr_o), .s_dat_i(s_dat_i), .s_dat_o(s_dat_o), .s_we_o(s_we_o), .s_sel_o(s_sel_o),
    .s_stb_o(s_stb_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_cyc_o(s_cyc_o),
    .timeout_o(timeout_o), .retry_o(retry_o)
  );

  wb_reg_timeout #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .SELECT_WIDTH(4), .TIMEOUT(0), .RETRY_LIMIT(0)) dut_z (
    .clk(clk), .rst(rst),
    .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_dat_o(z_m_dat_o), .m_we_i(m_we_i), .m_sel_i(m_sel_i),
    .m_stb_i(m_stb_i), .m_ack_o(z_m_ack_o), .m_err_o(z_m_err_o), .m_rty_o(z_m_rty_o), .m_cyc_i(m_cyc_i),
    .s_adr_o(z_s_adr_o), .s_dat_i(s_dat_i), .s_dat_o(z_s_dat_o), .s_we_o(z_s_we_o), .s_sel_o(z_s_sel_o),
    .s_stb_o(z_s_stb_o), .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i), .s_cyc_o(z_s_cyc_o),
    .timeout_o(z_timeout_o), .retry_o(z_retry_o)
  );

  // Inputs change and outputs are sampled 1 time unit after each rising edge.
  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic master_idle(input int n);
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    s_ack_i = 1'b0; s_err_i = 1'b0; s_rty_i = 1'b0;
    repeat (n) tick;
  endtask

  task automatic drive_req(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel);
    m_cyc_i = 1'b1; m_stb_i = 1'b1;
    m_we_i = we; m_adr_i = adr; m_dat_i = dat; m_sel_i = sel;
  endtask

  function automatic logic [33:0] observed();
    logic [1:0] code;
    code = m_ack_o ? 2'd1 : m_err_o ? 2'd2 : m_rty_o ? 2'd3 : 2'd0;
    return {code, (code == 2'd1) ? m_dat_o : 32'h0};
  endfunction

  function automatic logic [33:0] pop_exp();
    if (exp_q.size() == 0) return 34'h3_ffff_ffff;
    return exp_q.pop_front();
  endfunction

  task automatic test_reset;
    rst = 1'b1;
    master_idle(3);
    total++;
    if ({m_ack_o, m_err_o, m_rty_o, s_stb_o, s_cyc_o, s_we_o, timeout_o, retry_o} !== 8'h00 ||
        m_dat_o !== 32'h0 || s_adr_o !== 32'h0 || s_dat_o !== 32'h0 || s_sel_o !== 4'h0) begin
      bad++;
      $display("FAIL reset_values: ctl=%b m_dat=%h s_adr=%h s_dat=%h s_sel=%h required all zero",
               {m_ack_o, m_err_o, m_rty_o, s_stb_o, s_cyc_o, s_we_o, timeout_o, retry_o},
               m_dat_o, s_adr_o, s_dat_o, s_sel_o);
    end
    rst = 1'b0;
    tick;
  endtask

  // Full transfer acked on the 2nd strobe cycle; master keeps stb up through RESP.
  task automatic test_write;
    logic [33:0] got, exp;
    exp_q.push_back({2'd1, 32'hA5A5_0001});
    drive_req(1'b1, 32'h0000_0100, 32'h1122_3344, 4'hF);
    tick;
    total++;
    if (s_stb_o !== 1'b1 || s_cyc_o !== 1'b1 || s_adr_o !== 32'h100 || s_dat_o !== 32'h1122_3344 ||
        s_we_o !== 1'b1 || s_sel_o !== 4'hF) begin
      bad++;
      $display("FAIL write_issue: stb=%b cyc=%b adr=%h dat=%h we=%b sel=%h required 1 1 00000100 11223344 1 f",
               s_stb_o, s_cyc_o, s_adr_o, s_dat_o, s_we_o, s_sel_o);
    end
    tick;
    total++;
    if (s_stb_o !== 1'b1 || m_ack_o !== 1'b0) begin
      bad++;
      $display("FAIL write_wait: stb=%b ack=%b required 1 0", s_stb_o, m_ack_o);
    end
    s_ack_i = 1'b1; s_dat_i = 32'hA5A5_0001;
    tick;
    s_ack_i = 1'b0;
    got = observed();
    exp = pop_exp();
    total++;
    if (got !== exp || s_stb_o !== 1'b0) begin
      bad++;
      $display("FAIL write_resp: resp=%h stb=%b required %h 0", got, s_stb_o, exp);
    end
    tick;
    total++;
    if ({m_ack_o, m_err_o, m_rty_o} !== 3'b000 || s_stb_o !== 1'b0) begin
      bad++;
      $display("FAIL write_resp_end: ack/err/rty=%b stb=%b required 000 0", {m_ack_o, m_err_o, m_rty_o}, s_stb_o);
    end
    master_idle(2);
    total++;
    if (s_adr_o !== 32'h100 || s_dat_o !== 32'h1122_3344 || s_sel_o !== 4'hF) begin
      bad++;
      $display("FAIL write_hold: adr=%h dat=%h sel=%h required 00000100 11223344 f", s_adr_o, s_dat_o, s_sel_o);
    end
  endtask

  // Generic transfer: slave answers with kind (1=ack, 2=err) after delay strobe cycles.
  task automatic xfer(input logic we, input logic [31:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                      input int delay, input logic [1:0] kind, input logic [31:0] rdata);
    logic [33:0] got, exp;
    int lat;
    exp_q.push_back({kind, (kind == 2'd1) ? rdata : 32'h0});
    drive_req(we, adr, dat, sel);
    tick;
    total++;
    if (s_stb_o !== 1'b1 || s_adr_o !== adr || s_dat_o !== dat || s_we_o !== we || s_sel_o !== sel) begin
      bad++;
      $display("FAIL xfer_issue: stb=%b adr=%h dat=%h we=%b sel=%h required 1 %h %h %b %h",
               s_stb_o, s_adr_o, s_dat_o, s_we_o, s_sel_o, adr, dat, we, sel);
    end
    repeat (delay) tick;
    s_dat_i = rdata; s_ack_i = (kind == 2'd1); s_err_i = (kind == 2'd2);
    lat = 0;
    do begin
      tick;
      lat++;
      s_ack_i = 1'b0; s_err_i = 1'b0;
    end while ({m_ack_o, m_err_o, m_rty_o} == 3'b000 && lat < 20);
    total++;
    if (lat != 1) begin
      bad++;
      $display("FAIL xfer_latency: cycles=%0d required 1", lat);
    end
    got = observed();
    exp = pop_exp();
    total++;
    if (got !== exp || s_stb_o !== 1'b0 || timeout_o !== 1'b0) begin
      bad++;
      $display("FAIL xfer_resp: resp=%h stb=%b timeout=%b required %h 0 0", got, s_stb_o, timeout_o, exp);
    end
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    tick;
    total++;
    if ({m_ack_o, m_err_o, m_rty_o} !== 3'b000) begin
      bad++;
      $display("FAIL xfer_pulse: ack/err/rty=%b required 000", {m_ack_o, m_err_o, m_rty_o});
    end
  endtask

  task automatic test_read;
    xfer(1'b0, 32'h0000_0040, 32'h0, 4'hF, 1, 2'd1, 32'hDEAD_BEEF);
    xfer(1'b0, 32'h0000_0044, 32'h0, 4'h3, 0, 2'd2, 32'h0);
    master_idle(1);
  endtask

  task automatic test_timeout;
    logic [33:0] got, exp;
    int stb_cycles, to_p, err_p, ack_p, z_err, z_to, z_stb_low;
    got = '0;
    stb_cycles = 0; to_p = 0; err_p = 0; ack_p = 0; z_err = 0; z_to = 0; z_stb_low = 0;
    exp_q.push_back({2'd2, 32'h0});
    drive_req(1'b0, 32'h0000_0200, 32'h0, 4'hF);
    tick;
    for (int i = 0; i < 110; i++) begin
      if (s_stb_o) stb_cycles++;
      if (timeout_o) to_p++;
      if (m_ack_o) ack_p++;
      if (m_err_o) begin
        err_p++;
        got = observed();
        m_stb_i = 1'b0;  // cyc stays high so dut_z keeps its transfer open
      end
      if (z_m_err_o || z_m_ack_o || z_m_rty_o) z_err++;
      if (z_timeout_o) z_to++;
      if (!z_s_stb_o) z_stb_low++;
      tick;
    end
    exp = pop_exp();
    total++;
    if (stb_cycles != 8 || to_p != 1 || err_p != 1 || ack_p != 0) begin
      bad++;
      $display("FAIL timeout_pulses: stb_cycles=%0d timeout=%0d err=%0d ack=%0d required 8 1 1 0",
               stb_cycles, to_p, err_p, ack_p);
    end
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL timeout_resp: resp=%h required %h", got, exp);
    end
    total++;
    if (z_err != 0 || z_to != 0 || z_stb_low != 0) begin
      bad++;
      $display("FAIL timeout_disabled: resp=%0d timeout=%0d stb_low=%0d required 0 0 0", z_err, z_to, z_stb_low);
    end
    m_cyc_i = 1'b0;
    tick;
    total++;
    if (z_s_cyc_o !== 1'b0 || z_s_stb_o !== 1'b0 || {z_m_ack_o, z_m_err_o, z_m_rty_o} !== 3'b000) begin
      bad++;
      $display("FAIL timeout_disabled_abort: cyc=%b stb=%b resp=%b required 0 0 000",
               z_s_cyc_o, z_s_stb_o, {z_m_ack_o, z_m_err_o, z_m_rty_o});
    end
    master_idle(2);
  endtask

  task automatic test_retry;
    logic [33:0] got, exp;
    exp_q.push_back({2'd3, 32'h0});
    drive_req(1'b1, 32'h0000_0300, 32'hCAFE_0003, 4'h1);
    tick;
    for (int r = 0; r < 2; r++) begin
      s_rty_i = 1'b1;
      tick;
      s_rty_i = 1'b0;
      total++;
      if (retry_o !== 1'b1 || s_stb_o !== 1'b0 || s_cyc_o !== 1'b0 || m_rty_o !== 1'b0) begin
        bad++;
        $display("FAIL retry_pulse%0d: retry=%b stb=%b cyc=%b m_rty=%b required 1 0 0 0",
                 r, retry_o, s_stb_o, s_cyc_o, m_rty_o);
      end
      if (r == 0) begin
        total++;
        if (z_m_rty_o !== 1'b1 || z_retry_o !== 1'b0) begin
          bad++;
          $display("FAIL retry_passthrough: m_rty=%b retry=%b required 1 0", z_m_rty_o, z_retry_o);
        end
      end
      s_ack_i = (r == 0);  // an ack during backoff must be ignored
      tick;
      s_ack_i = 1'b0;
      total++;
      if (s_stb_o !== 1'b1 || retry_o !== 1'b0 || m_ack_o !== 1'b0 || s_adr_o !== 32'h300 ||
          s_dat_o !== 32'hCAFE_0003) begin
        bad++;
        $display("FAIL retry_restrobe%0d: stb=%b retry=%b ack=%b adr=%h dat=%h required 1 0 0 00000300 cafe0003",
                 r, s_stb_o, retry_o, m_ack_o, s_adr_o, s_dat_o);
      end
    end
    s_rty_i = 1'b1;
    tick;
    s_rty_i = 1'b0;
    got = observed();
    exp = pop_exp();
    total++;
    if (got !== exp || retry_o !== 1'b0 || s_stb_o !== 1'b0) begin
      bad++;
      $display("FAIL retry_limit: resp=%h retry=%b stb=%b required %h 0 0", got, retry_o, s_stb_o, exp);
    end
    s_ack_i = 1'b1;
    tick;
    s_ack_i = 1'b0;
    total++;
    if ({m_ack_o, m_err_o, m_rty_o} !== 3'b000) begin
      bad++;
      $display("FAIL retry_no_ack: ack/err/rty=%b required 000", {m_ack_o, m_err_o, m_rty_o});
    end
    master_idle(3);
  endtask

  task automatic test_abort;
    int resp;
    drive_req(1'b0, 32'h0000_0400, 32'h0, 4'hF);
    tick;
    tick;
    tick;
    m_cyc_i = 1'b0; m_stb_i = 1'b0;
    s_ack_i = 1'b1;  // abort outranks a simultaneous ack
    tick;
    s_ack_i = 1'b0;
    resp = 0;
    total++;
    if (s_cyc_o !== 1'b0 || s_stb_o !== 1'b0) begin
      bad++;
      $display("FAIL abort_drop: cyc=%b stb=%b required 0 0", s_cyc_o, s_stb_o);
    end
    for (int i = 0; i < 4; i++) begin
      if (m_ack_o || m_err_o || m_rty_o) resp++;
      tick;
    end
    total++;
    if (resp != 0) begin
      bad++;
      $display("FAIL abort_resp: responses=%0d required 0", resp);
    end
    xfer(1'b1, 32'h0000_0404, 32'h5555_AAAA, 4'hC, 2, 2'd1, 32'h0000_0404);
    master_idle(1);
  endtask

  task automatic check_all_zero(input string name);
    total++;
    if ({m_ack_o, m_err_o, m_rty_o, s_stb_o, s_cyc_o, s_we_o, timeout_o, retry_o} !== 8'h00 ||
        m_dat_o !== 32'h0 || s_adr_o !== 32'h0 || s_dat_o !== 32'h0 || s_sel_o !== 4'h0) begin
      bad++;
      $display("FAIL %s: ctl=%b m_dat=%h s_adr=%h s_dat=%h s_sel=%h required all zero", name,
               {m_ack_o, m_err_o, m_rty_o, s_stb_o, s_cyc_o, s_we_o, timeout_o, retry_o},
               m_dat_o, s_adr_o, s_dat_o, s_sel_o);
    end
  endtask

  task automatic test_reset_mid;
    for (int ph = 0; ph < 2; ph++) begin
      drive_req(1'b1, 32'h0000_0500, 32'h1234_5678, 4'hF);
      tick;
      if (ph == 1) begin
        s_rty_i = 1'b1;  // enter BACKOFF before the reset
        tick;
        s_rty_i = 1'b0;
      end
      rst = 1'b1;
      tick;
      check_all_zero(ph == 0 ? "reset_in_issue" : "reset_in_backoff");
      rst = 1'b0;
      m_cyc_i = 1'b0; m_stb_i = 1'b0;
      s_ack_i = 1'b1;
      tick;
      s_ack_i = 1'b0;
      tick;
      total++;
      if ({m_ack_o, m_err_o, m_rty_o, retry_o, s_stb_o} !== 5'b00000) begin
        bad++;
        $display("FAIL reset_stray_ack%0d: ack/err/rty/retry/stb=%b required 00000", ph,
                 {m_ack_o, m_err_o, m_rty_o, retry_o, s_stb_o});
      end
    end
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      xfer(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
           $urandom_range(0, 5), 2'($urandom_range(1, 2)), $urandom);
    end
    master_idle(1);
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: left=%0d required 0", exp_q.size());
    end
  endtask

  initial begin
    test_reset;
    test_write;
    test_read;
    test_timeout;
    test_retry;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule

// File: doc/wb_reg_timeout.md
Name: wb_reg_timeout

Overview:
Wishbone classic register slice between a master port (m_*) and a slave port (s_*) that registers every request and response path. It adds a per-transfer watchdog that ends stalled transfers with an error. It also reissues transfers automatically when the slave signals retry, up to a configurable limit. It sits in bus fabrics in front of slow or unreliable slaves and keeps masters from hanging.

Parameters:
DATA_WIDTH, 32, data bus width in bits
ADDR_WIDTH, 32, address bus width in bits
SELECT_WIDTH, DATA_WIDTH/8, byte-select width
TIMEOUT, 1024, cycles of s_stb_o without a slave response before abort; 0 disables the watchdog
RETRY_LIMIT, 3, automatic reissues on s_rty_i before m_rty_o is returned; 0 passes rty straight through

Ports:
clk  input  1  clock
rst  input  1  reset
m_adr_i  input  ADDR_WIDTH  master address
m_dat_i  input  DATA_WIDTH  master write data
m_dat_o  output  DATA_WIDTH  read data to master
m_we_i  input  1  master write enable
m_sel_i  input  SELECT_WIDTH  master byte select
m_stb_i  input  1  master strobe
m_ack_o  output  1  ack to master
m_err_o  output  1  error to master
m_rty_o  output  1  retry to master
m_cyc_i  input  1  master cycle
s_adr_o  output  ADDR_WIDTH  slave address
s_dat_i  input  DATA_WIDTH  slave read data
s_dat_o  output  DATA_WIDTH  slave write data
s_we_o  output  1  slave write enable
s_sel_o  output  SELECT_WIDTH  slave byte select
s_stb_o  output  1  slave strobe
s_ack_i  input  1  slave ack
s_err_i  input  1  slave error
s_rty_i  input  1  slave retry
s_cyc_o  output  1  slave cycle
timeout_o  output  1  one-cycle pulse when the watchdog aborts a transfer
retry_o  output  1  one-cycle pulse on each automatic reissue

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; it acts in any state.
- Reset values: all outputs 0, state IDLE, timer 0, retry count 0.
- Timer width is $clog2(TIMEOUT+1). Retry count width is $clog2(RETRY_LIMIT+1).
- State machine: IDLE, ISSUE, BACKOFF, RESP.
- IDLE:
  - On m_cyc_i && m_stb_i, capture adr/dat/we/sel into s_adr_o/s_dat_o/s_we_o/s_sel_o.
  - Set s_cyc_o = s_stb_o = 1, timer = TIMEOUT-1, retry count = 0, then go to ISSUE.
- ISSUE, response priority s_ack_i > s_err_i > s_rty_i > timeout:
  - s_ack_i: clear s_cyc_o/s_stb_o, m_dat_o <= s_dat_i (reads and writes alike), m_ack_o <= 1, go to RESP.
  - s_err_i: clear s_cyc_o/s_stb_o, m_err_o <= 1, go to RESP.
  - s_rty_i with retry count < RETRY_LIMIT: clear s_cyc_o/s_stb_o, increment retry count, pulse retry_o, go to BACKOFF.
  - s_rty_i with retry count == RETRY_LIMIT: clear s_cyc_o/s_stb_o, m_rty_o <= 1, go to RESP.
  - No response, TIMEOUT != 0, timer == 0: clear s_cyc_o/s_stb_o, m_err_o <= 1, pulse timeout_o, go to RESP.
  - Otherwise decrement the timer; with TIMEOUT == 0 the timer is held and never expires.
- Master abort: m_cyc_i low in ISSUE or BACKOFF (checked before slave responses) clears s_cyc_o/s_stb_o and goes to IDLE. No master response is generated.
- BACKOFF: exactly one idle cycle. Then re-assert s_cyc_o/s_stb_o with the same captured fields, reload timer = TIMEOUT-1, go to ISSUE.
- RESP:
  - m_ack_o/m_err_o/m_rty_o stay high for exactly this one cycle, then clear; go to IDLE.
  - The still-asserted m_stb_i is not treated as a new request in this cycle.
- Latency:
  - Request seen at edge N drives s_stb_o high in cycle N+1.
  - Slave response at edge K drives the m_* response in cycle K+1.
  - The next request is accepted no earlier than the edge after RESP.
- Outputs are exclusive: at most one of m_ack_o/m_err_o/m_rty_o is high, and only in RESP.
- s_* address/data/we/sel hold their value outside transfers.
- A slave response seen in IDLE or BACKOFF is ignored.
- Reset mid-transfer: outputs return to reset values on the next edge with no response pulse.

Test Plan:
- Write adr=0x0000_0100, dat=0x1122_3344, sel=0xF; slave acks on its 2nd strobe cycle -> s_stb_o high from cycle 1; m_ack_o a single pulse one cycle after s_ack_i; s_dat_o=0x1122_3344.
- Read with the slave acking and s_dat_i=0xDEAD_BEEF -> m_dat_o=0xDEAD_BEEF while m_ack_o=1; m_err_o and m_rty_o stay 0.
- TIMEOUT=8, slave silent -> s_stb_o high 8 cycles then low; m_err_o and timeout_o pulse once. Repeat with TIMEOUT=0 for 100 cycles -> no error.
- RETRY_LIMIT=2, slave rtys three times then would ack -> 2 retry_o pulses, each followed by a 1-cycle gap and re-strobe; third rty yields m_rty_o, no m_ack_o.
- Master drops m_cyc_i on the 3rd strobe cycle -> s_cyc_o low the next cycle; no m_ack/err/rty; a fresh request is then accepted normally.
- Assert rst during ISSUE and during BACKOFF -> all outputs 0 the next cycle; s_ack_i asserted after reset produces no m_ack_o.
